// File: rtl/register_file_8x.sv
// 8-entry register file written through a one-hot select, with two registered read ports.
// Write selects with more than one bit set are rejected and flagged.
module register_file_8x #(
  parameter int DATA_WIDTH = 8,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_onehot,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [2:0]            rd_addr_a,
  input  logic [2:0]            rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  wr_err,
  output logic                  wr_err_stky,
  output logic [7:0]            wr_count
);

  localparam int NREG = 8;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic                  wr_err_q, wr_err_d;
  logic                  wr_err_stky_q, wr_err_stky_d;
  logic [7:0]            wr_count_q, wr_count_d;

  logic wr_multi;
  logic wr_legal;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign wr_multi = (wr_onehot & (wr_onehot - 8'd1)) != 8'd0;
  assign wr_legal = (wr_onehot != 8'd0) && !wr_multi;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_legal && wr_onehot[i]) begin
        regs_d[i] = wr_data;
      end
    end
  end

  // Forwarding only ever uses a legal write; a rejected write is invisible to readers.
  always_comb begin
    rd_data_a_d = regs_q[rd_addr_a];
    rd_data_b_d = regs_q[rd_addr_b];
    if (BYPASS && wr_legal && wr_onehot[rd_addr_a]) begin
      rd_data_a_d = wr_data;
    end
    if (BYPASS && wr_legal && wr_onehot[rd_addr_b]) begin
      rd_data_b_d = wr_data;
    end
  end

  always_comb begin
    wr_err_d      = wr_multi;
    wr_err_stky_d = wr_err_stky_q | wr_multi;
    wr_count_d    = wr_count_q + {7'd0, wr_legal};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      rd_data_a_q   <= '0;
      rd_data_b_q   <= '0;
      wr_err_q      <= 1'b0;
      wr_err_stky_q <= 1'b0;
      wr_count_q    <= 8'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_data_a_q   <= rd_data_a_d;
      rd_data_b_q   <= rd_data_b_d;
      wr_err_q      <= wr_err_d;
      wr_err_stky_q <= wr_err_stky_d;
      wr_count_q    <= wr_count_d;
    end
  end

  assign rd_data_a   = rd_data_a_q;
  assign rd_data_b   = rd_data_b_q;
  assign wr_err      = wr_err_q;
  assign wr_err_stky = wr_err_stky_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_register_file_8x.sv
// Scoreboard bench for register_file_8x: one instance with forwarding, one without,
// driven by the same directed vectors.
module tb_register_file_8x;

  logic       clk;
  logic       rst;
  logic [7:0] wr_onehot;
  logic [7:0] wr_data;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;

  logic [7:0] a1, b1, cnt1;
  logic       err1, stky1;
  logic [7:0] a0, b0, cnt0;
  logic       err0, stky0;

  int checks = 0;
  int errors = 0;

  register_file_8x #(.DATA_WIDTH(8), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .wr_onehot(wr_onehot), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a1), .rd_data_b(b1), .wr_err(err1), .wr_err_stky(stky1), .wr_count(cnt1)
  );

  register_file_8x #(.DATA_WIDTH(8), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst(rst), .wr_onehot(wr_onehot), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a0), .rd_data_b(b0), .wr_err(err0), .wr_err_stky(stky0), .wr_count(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a1, b1, a0, b0;
    logic       err, stky;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_regs [8];
  logic       m_stky;
  logic [7:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_stky = 1'b0;
    m_cnt  = 8'd0;
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input logic [7:0] oh, input logic [7:0] d,
                      input logic [2:0] ra, input logic [2:0] rb);
    exp_t e;
    bit   legal;
    bit   multi;
    @(negedge clk);
    wr_onehot = oh;
    wr_data   = d;
    rd_addr_a = ra;
    rd_addr_b = rb;
    legal = ($countones(oh) == 1);
    multi = ($countones(oh) > 1);
    e.a0 = m_regs[ra];
    e.b0 = m_regs[rb];
    e.a1 = (legal && oh[ra]) ? d : m_regs[ra];
    e.b1 = (legal && oh[rb]) ? d : m_regs[rb];
    if (legal) begin
      for (int i = 0; i < 8; i++) if (oh[i]) m_regs[i] = d;
      m_cnt = m_cnt + 8'd1;
    end
    if (multi) m_stky = 1'b1;
    e.err  = multi;
    e.stky = m_stky;
    e.cnt  = m_cnt;
    sb.push_back(e);
    $display("txn oh=%b data=%h ra=%0d rb=%0d -> exp a1=%h b1=%h a0=%h b0=%h err=%b stky=%b cnt=%0d",
             oh, d, ra, rb, e.a1, e.b1, e.a0, e.b0, e.err, e.stky, e.cnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a1"}, a1, 0);
    chk({tag, "_b1"}, b1, 0);
    chk({tag, "_a0"}, a0, 0);
    chk({tag, "_b0"}, b0, 0);
    chk({tag, "_err1"}, err1, 0);
    chk({tag, "_err0"}, err0, 0);
    chk({tag, "_stky1"}, stky1, 0);
    chk({tag, "_stky0"}, stky0, 0);
    chk({tag, "_cnt1"}, cnt1, 0);
    chk({tag, "_cnt0"}, cnt0, 0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every clock edge with a pending expectation yields one compare set.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_a_byp", a1, e.a1);
      chk("rd_b_byp", b1, e.b1);
      chk("rd_a_nobyp", a0, e.a0);
      chk("rd_b_nobyp", b0, e.b0);
      chk("wr_err_byp", err1, e.err);
      chk("wr_err_nobyp", err0, e.err);
      chk("stky_byp", stky1, e.stky);
      chk("stky_nobyp", stky0, e.stky);
      chk("count_byp", cnt1, e.cnt);
      chk("count_nobyp", cnt0, e.cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    wr_onehot = 8'h00;
    wr_data = 8'h00;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    model_clear();

    // Reset held while inputs toggle randomly.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wr_onehot = 8'($urandom);
      wr_data   = 8'($urandom);
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = 3'($urandom_range(0, 7));
      after_edge();
      check_zero("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    wr_onehot = 8'h00;
    for (int i = 0; i < 8; i++) step(8'h00, 8'hEE, 3'(i), 3'(7 - i));

    // Write/read sweep.
    for (int i = 0; i < 8; i++) step(8'h01 << i, 8'hA0 + 8'(i), 3'(7 - i), 3'(i));
    for (int i = 0; i < 8; i++) step(8'h00, 8'h00, 3'(i), 3'(7 - i));
    after_edge();
    chk("sweep_count", cnt1, 8);
    chk("sweep_a_last", a1, 8'hA7);
    chk("sweep_b_last", b1, 8'hA0);

    // Read-during-write on reg3.
    step(8'h08, 8'h11, 3'd3, 3'd3);
    step(8'h08, 8'h5C, 3'd3, 3'd0);
    after_edge();
    chk("bypass1_new", a1, 8'h5C);
    chk("bypass0_old", a0, 8'h11);
    step(8'h00, 8'h00, 3'd3, 3'd3);
    after_edge();
    chk("bypass0_follow", a0, 8'h5C);

    // Illegal enable, read addresses aimed at the targeted registers.
    step(8'b0000_0110, 8'hFF, 3'd1, 3'd2);
    after_edge();
    chk("illegal_err", err1, 1);
    chk("illegal_a_nobypass", a1, 8'hA1);
    step(8'h00, 8'h00, 3'd1, 3'd2);
    after_edge();
    chk("illegal_err_pulse", err1, 0);
    chk("illegal_stky", stky1, 1);
    chk("illegal_reg2", b1, 8'hA2);
    chk("illegal_count", cnt1, 10);

    // Idle.
    for (int i = 0; i < 10; i++) step(8'h00, 8'($urandom), 3'(i % 8), 3'((i + 3) % 8));

    // Asynchronous reset in the middle of a write burst.
    step(8'h10, 8'h33, 3'd4, 3'd5);
    step(8'h20, 8'h44, 3'd5, 3'd4);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    sb.delete();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_onehot = 8'h00;
    for (int i = 0; i < 8; i++) step(8'h00, 8'h00, 3'(i), 3'(7 - i));

    // 256 legal writes wrap the counter back to zero.
    for (int k = 0; k < 256; k++) step(8'h01 << (k % 8), 8'(k), 3'(k % 8), 3'((k + 1) % 8));
    after_edge();
    chk("wrap_count_byp", cnt1, 0);
    chk("wrap_count_nobyp", cnt0, 0);
    chk("wrap_stky", stky1, 0);

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
